// File: rtl/ship_anim_ctrl.sv
// ship_anim_ctrl - ship animation and lifecycle controller.
//
// Sequences the thrust-flame frames. On a collision it runs the explosion
// frames, then keeps the ship invisible for a wait period. It then respawns
// the ship with an invulnerability window. It counts lives down to game over
// and waits there for a restart.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   anim_pulse   one-cycle animation tick
//   thrust       engine button (level)
//   collision    ship hit (level, sampled every cycle)
//   restart      one-cycle restart request, honoured only in game over
//   rom_base     sprite ROM base address of the current frame
//   height       sprite height for the drawer
//   draw_en      gate on the drawer's draw output
//   collide_en   collisions are counted only while high
//   respawn_req  one-cycle pulse: motion block recenters and zeroes velocity
//   thrust_en    thrust forwarded to the motion block (ALIVE/BLINK only)
//   lives_left   remaining lives
//   game_over    high while in game over
//
// Build option: define SHIP_BLINK_EN to make the sprite blink during the
// invulnerability window. draw_en then toggles on every anim_pulse and starts
// at 1. Without the macro, draw_en stays at 1 for the whole window.
module ship_anim_ctrl #(
  parameter int ANIM_FRAMES     = 4,
  parameter int FRAME_SIZE      = 1020,
  parameter int EXPL_FRAMES     = 8,
  parameter int EXPL_FRAME_SIZE = 1024,
  parameter int EXPL_BASE       = 4080,
  parameter int RESPAWN_PULSES  = 30,
  parameter int BLINK_PULSES    = 40,
  parameter int LIVES           = 3,
  parameter int HEIGHT_IDLE     = 26,
  parameter int HEIGHT_THRUST   = 34,
  parameter int HEIGHT_EXPL     = 32,
  parameter int BASE_W          = $clog2(EXPL_BASE + EXPL_FRAMES * EXPL_FRAME_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              anim_pulse,
  input  logic              thrust,
  input  logic              collision,
  input  logic              restart,
  output logic [BASE_W-1:0] rom_base,
  output logic [8:0]        height,
  output logic              draw_en,
  output logic              collide_en,
  output logic              respawn_req,
  output logic              thrust_en,
  output logic [3:0]        lives_left,
  output logic              game_over
);

  localparam int F_W   = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int E_W   = (EXPL_FRAMES > 1) ? $clog2(EXPL_FRAMES) : 1;
  localparam int C_MAX = (RESPAWN_PULSES > BLINK_PULSES) ? RESPAWN_PULSES : BLINK_PULSES;
  localparam int C_W   = (C_MAX > 1) ? $clog2(C_MAX) : 1;

  localparam logic [F_W-1:0]    F_LAST       = F_W'(ANIM_FRAMES - 1);
  localparam logic [E_W-1:0]    E_LAST       = E_W'(EXPL_FRAMES - 1);
  localparam logic [C_W-1:0]    RESPAWN_LAST = C_W'(RESPAWN_PULSES - 1);
  localparam logic [C_W-1:0]    BLINK_LAST   = C_W'(BLINK_PULSES - 1);
  localparam logic [BASE_W-1:0] FRAME_SZ     = BASE_W'(FRAME_SIZE);
  localparam logic [BASE_W-1:0] EXPL_SZ      = BASE_W'(EXPL_FRAME_SIZE);
  localparam logic [BASE_W-1:0] EXPL_ADDR    = BASE_W'(EXPL_BASE);

  typedef enum logic [2:0] {
    ST_ALIVE     = 3'd0,
    ST_EXPLODE   = 3'd1,
    ST_DEAD_WAIT = 3'd2,
    ST_BLINK     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  state_t         state, nxt_state;
  logic [F_W-1:0] f, nxt_f, flame_next;
  logic [E_W-1:0] e, nxt_e;
  logic [C_W-1:0] cnt, nxt_cnt;
  logic [3:0]     nxt_lives;
  logic           vis, nxt_vis, nxt_respawn;

  logic [BASE_W-1:0] nxt_rom_base;
  logic [8:0]        nxt_height;
  logic              nxt_draw_en;

  // Flame frame under thrust: idle frame when the engine is off, advance on ticks
  always_comb begin
    if (!thrust) begin
      flame_next = '0;
    end else if (anim_pulse) begin
      flame_next = (f == F_LAST) ? '0 : f + F_W'(1);
    end else begin
      flame_next = f;
    end
  end

  // Lifecycle next-state and counter updates
  always_comb begin
    nxt_state   = state;
    nxt_f       = f;
    nxt_e       = e;
    nxt_cnt     = cnt;
    nxt_lives   = lives_left;
    nxt_vis     = vis;
    nxt_respawn = 1'b0;
    case (state)
      ST_ALIVE: begin
        // A collision takes priority over a tick in the same cycle
        if (collision) begin
          nxt_state = ST_EXPLODE;
          nxt_lives = lives_left - 4'd1;
          nxt_e     = '0;
        end else begin
          nxt_f = flame_next;
        end
      end
      ST_EXPLODE: begin
        if (anim_pulse) begin
          if (e == E_LAST) begin
            nxt_state = (lives_left == 4'd0) ? ST_GAME_OVER : ST_DEAD_WAIT;
            nxt_cnt   = '0;
          end else begin
            nxt_e = e + E_W'(1);
          end
        end else begin
          nxt_e = e;
        end
      end
      ST_DEAD_WAIT: begin
        if (anim_pulse) begin
          if (cnt == RESPAWN_LAST) begin
            nxt_state   = ST_BLINK;
            nxt_cnt     = '0;
            nxt_f       = '0;
            nxt_vis     = 1'b1;
            nxt_respawn = 1'b1;
          end else begin
            nxt_cnt = cnt + C_W'(1);
          end
        end else begin
          nxt_cnt = cnt;
        end
      end
      ST_BLINK: begin
        // Collisions are ignored while the ship is invulnerable
        if (anim_pulse && (cnt == BLINK_LAST)) begin
          nxt_state = ST_ALIVE;
          nxt_f     = '0;
          nxt_cnt   = '0;
          nxt_vis   = 1'b1;
        end else begin
          nxt_f = flame_next;
          if (anim_pulse) begin
            nxt_cnt = cnt + C_W'(1);
          end else begin
            nxt_cnt = cnt;
          end
`ifdef SHIP_BLINK_EN
          nxt_vis = anim_pulse ? ~vis : vis;
`else
          nxt_vis = 1'b1;
`endif
        end
      end
      ST_GAME_OVER: begin
        if (restart) begin
          nxt_state   = ST_BLINK;
          nxt_lives   = 4'(LIVES);
          nxt_cnt     = '0;
          nxt_f       = '0;
          nxt_vis     = 1'b1;
          nxt_respawn = 1'b1;
        end else begin
          nxt_state = ST_GAME_OVER;
        end
      end
      default: begin
        nxt_state = ST_ALIVE;
        nxt_f     = '0;
        nxt_e     = '0;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Sprite selection from the upcoming state so outputs register alongside it
  always_comb begin
    nxt_rom_base = '0;
    nxt_height   = 9'(HEIGHT_IDLE);
    nxt_draw_en  = 1'b0;
    case (nxt_state)
      ST_ALIVE, ST_BLINK: begin
        nxt_rom_base = BASE_W'(nxt_f) * FRAME_SZ;
        nxt_height   = thrust ? 9'(HEIGHT_THRUST) : 9'(HEIGHT_IDLE);
        nxt_draw_en  = (nxt_state == ST_ALIVE) ? 1'b1 : nxt_vis;
      end
      ST_EXPLODE: begin
        nxt_rom_base = EXPL_ADDR + BASE_W'(nxt_e) * EXPL_SZ;
        nxt_height   = 9'(HEIGHT_EXPL);
        nxt_draw_en  = 1'b1;
      end
      default: begin
        nxt_rom_base = '0;
        nxt_height   = 9'(HEIGHT_IDLE);
        nxt_draw_en  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_ALIVE;
      f           <= '0;
      e           <= '0;
      cnt         <= '0;
      vis         <= 1'b1;
      rom_base    <= '0;
      height      <= 9'(HEIGHT_IDLE);
      draw_en     <= 1'b1;
      collide_en  <= 1'b1;
      respawn_req <= 1'b0;
      thrust_en   <= 1'b0;
      lives_left  <= 4'(LIVES);
      game_over   <= 1'b0;
    end else begin
      state       <= nxt_state;
      f           <= nxt_f;
      e           <= nxt_e;
      cnt         <= nxt_cnt;
      vis         <= nxt_vis;
      rom_base    <= nxt_rom_base;
      height      <= nxt_height;
      draw_en     <= nxt_draw_en;
      collide_en  <= (nxt_state == ST_ALIVE);
      respawn_req <= nxt_respawn;
      thrust_en   <= thrust && ((nxt_state == ST_ALIVE) || (nxt_state == ST_BLINK));
      lives_left  <= nxt_lives;
      game_over   <= (nxt_state == ST_GAME_OVER);
    end
  end

endmodule

// File: doc/ship_anim_ctrl.md
# ship_anim_ctrl

Parametrised ship animation and lifecycle controller: the next generation of the ship unit's flame-frame logic. It sequences thrust-flame frames, runs an explosion sequence on collision, waits, respawns with an invulnerability window, and tracks lives through to game over. It sits between the collision detector, the ship motion block and the sprite drawer, and produces the sprite ROM base address, sprite height, draw gate and collision-enable for that ship.

## Interface
- ANIM_FRAMES, 4: thrust flame frames; ≥2.
- FRAME_SIZE, 1020: ROM words per flame frame.
- EXPL_FRAMES, 8: explosion frames; ≥1.
- EXPL_FRAME_SIZE, 1024: ROM words per explosion frame.
- EXPL_BASE, 4080: ROM address of explosion frame 0; must be ≥ ANIM_FRAMES*FRAME_SIZE.
- RESPAWN_PULSES, 30: anim_pulse count spent invisible before respawn; ≥1.
- BLINK_PULSES, 40: anim_pulse count of invulnerability after respawn; ≥1.
- LIVES, 3: lives at reset/restart; 1..15.
- HEIGHT_IDLE, 26 / HEIGHT_THRUST, 34 / HEIGHT_EXPL, 32: sprite heights per mode.
- BASE_W: derived, clog2(EXPL_BASE + EXPL_FRAMES*EXPL_FRAME_SIZE).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- anim_pulse  in  1  one-cycle animation tick.
- thrust  in  1  engine button (level).
- collision  in  1  ship hit (level, sampled each cycle).
- restart  in  1  one-cycle restart request; honoured only in GAME_OVER.
- rom_base  out  BASE_W  sprite ROM base address of current frame.
- height  out  9  sprite height for the drawer.
- draw_en  out  1  gate on the drawer's Draw output.
- collide_en  out  1  collisions counted only when high.
- respawn_req  out  1  one-cycle pulse telling motion block to recenter and zero velocity.
- thrust_en  out  1  thrust forwarded to motion block; low except in ALIVE/BLINK.
- lives_left  out  4  remaining lives.
- game_over  out  1  high in GAME_OVER.

## Operation
- States: ALIVE, EXPLODE, DEAD_WAIT, BLINK, GAME_OVER. Reset -> ALIVE.
- ALIVE: thrust low -> flame frame f=0, height=HEIGHT_IDLE. Thrust high -> f increments on each anim_pulse, wraps ANIM_FRAMES-1 -> 0; height=HEIGHT_THRUST. rom_base = f*FRAME_SIZE. collision high -> EXPLODE, lives_left decrements, explosion frame e=0.
- EXPLODE: draw_en=1, collide_en=0, thrust_en=0, height=HEIGHT_EXPL, rom_base = EXPL_BASE + e*EXPL_FRAME_SIZE. e increments per anim_pulse; on the pulse with e=EXPL_FRAMES-1 -> GAME_OVER if lives_left=0, else DEAD_WAIT.
- DEAD_WAIT: draw_en=0, collide_en=0. Counts RESPAWN_PULSES pulses, then -> BLINK with respawn_req asserted that cycle.
- BLINK: sprite as ALIVE (flame animates), collide_en=0, collision ignored. Counts BLINK_PULSES pulses, then -> ALIVE, f=0.
- GAME_OVER: draw_en=0, collide_en=0, game_over=1. restart -> lives_left=LIVES, -> BLINK with respawn_req.
- Priority in one cycle: collision over anim_pulse (ALIVE); restart ignored outside GAME_OVER.
- All counters saturate-free: sized to parameter maxima, cleared on state entry.

## Timing
- All outputs registered; state/output change one clk after the triggering input edge.
- respawn_req exactly one cycle wide, coincident with first BLINK cycle.
- rom_base valid the cycle after any frame change; drawer latency unaffected.
- Reset values: state ALIVE, f=0, e=0, rom_base=0, height=HEIGHT_IDLE, draw_en=1, collide_en=1, thrust_en=0, respawn_req=0, lives_left=LIVES, game_over=0.
- Reset asserted mid-sequence returns to reset values immediately (async), no respawn_req.

## Configuration
- SHIP_BLINK_EN defined: draw_en in BLINK toggles on every anim_pulse, starting at 1 on entry.
- Not defined: draw_en held 1 throughout BLINK; invulnerability timing unchanged.

## Test plan
- Reset, thrust=1, 5 anim_pulses -> rom_base 1020, 2040, 3060, 0, 1020; height 34; thrust=0 -> rom_base 0, height 26.
- ALIVE, collision and anim_pulse same cycle -> EXPLODE, lives_left 3->2, rom_base 4080, collide_en 0.
- 8 pulses in EXPLODE -> DEAD_WAIT, draw_en 0; 30 pulses -> respawn_req one cycle, BLINK; collision during BLINK -> no state/lives change; 40 pulses -> ALIVE, collide_en 1.
- Three deaths from reset -> after third explosion GAME_OVER, game_over 1, lives_left 0; restart in ALIVE earlier ignored; restart now -> lives_left 3, respawn_req, BLINK.
- With SHIP_BLINK_EN: draw_en sequence in BLINK 1,0,1,0 per pulse; without: constant 1.
- Reset asserted mid-EXPLODE -> all outputs to reset values same cycle, respawn_req stays 0.
